// File: rtl/alarm_pkg.sv
// Shared types and helpers for the sensor/buzzer alarm controller.
// Used by the input front-end and by the buzzer state machine.
package alarm_pkg;

    localparam int N_SENSORS_MAX = 8;

    typedef logic [N_SENSORS_MAX-1:0] sensor_vec_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set_idx(input sensor_vec_t v);
        logic [2:0] idx;
        idx = '0;
        for (int i = N_SENSORS_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One sensor channel: 2-flop synchroniser, stability counter, clean level.
// rise is combinational so the event latch sets on the same edge as clean.
module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    // Next-state: synchroniser always shifts; debounce only advances when enabled.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (ena) begin
            if (s2_q == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                clean_d = s2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial debounce count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;
    assign rise  = clean_d & ~clean_q;

endmodule

// File: rtl/sensor_debounce_latch.sv
// Sensor input front-end: per-channel debounce, rising-edge event latch,
// lowest-index event report and saturating event counter.
module sensor_debounce_latch
    import alarm_pkg::*;
#(
    parameter int N_SENSORS       = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_SENSORS-1:0] sensor_raw,
    input  logic [N_SENSORS-1:0] ack,
    output logic [N_SENSORS-1:0] sensor_clean,
    output logic [N_SENSORS-1:0] event_latched,
    output logic                 event_valid,
    output logic [2:0]           event_id,
    output logic [CNT_W-1:0]     event_count
);

    localparam int SW = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_SENSORS-1:0] rise;
    logic [N_SENSORS-1:0] lat_q, lat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           pop;
    logic [SW-1:0]        sum;
    sensor_vec_t          lat_vec;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .ena  (ena),
            .raw  (sensor_raw[g]),
            .clean(sensor_clean[g]),
            .rise (rise[g])
        );
    end

    // Latch next-state (set wins over ack) and clamped event count.
    always_comb begin
        lat_d = (lat_q & ~ack) | rise;
        pop   = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            pop = pop + 4'(rise[i]);
        end
        sum = SW'(cnt_q) + SW'(pop);
        if (sum > SW'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Event latch and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
            cnt_q <= '0;
        end else begin
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

    // Report straight from the latch register; upper bits padded with zero.
    always_comb begin
        lat_vec                = '0;
        lat_vec[N_SENSORS-1:0] = lat_q;
    end

    assign event_latched = lat_q;
    assign event_valid   = |lat_q;
    assign event_id      = lowest_set_idx(lat_vec);
    assign event_count   = cnt_q;

endmodule

// File: tb/tb_sensor_debounce_latch.sv
// Bench for sensor_debounce_latch: directed scenarios plus random traffic,
// checked every cycle against a run-length reference model.
module tb_sensor_debounce_latch;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [N-1:0]  sensor_raw;
    logic [N-1:0]  ack;
    logic [N-1:0]  sensor_clean;
    logic [N-1:0]  event_latched;
    logic          event_valid;
    logic [2:0]    event_id;
    logic [CW-1:0] event_count;

    int checks   = 0;
    int failures = 0;

    // model: sync delay line, clean level, mismatch run length, latch, count
    logic [N-1:0] m_s1, m_s2, m_clean, m_lat;
    int           m_run [N];
    int           m_cnt;

    always #5 clk = ~clk;

    sensor_debounce_latch #(
        .N_SENSORS      (N),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sensor_raw   (sensor_raw),
        .ack          (ack),
        .sensor_clean (sensor_clean),
        .event_latched(event_latched),
        .event_valid  (event_valid),
        .event_id     (event_id),
        .event_count  (event_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] rise;
        int total;
        rise = '0;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_lat = '0; m_cnt = 0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ena) begin
                    if (m_s2[i] != m_clean[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= DEB) begin
                            m_clean[i] = m_s2[i];
                            m_run[i]   = 0;
                            rise[i]    = m_s2[i];
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_lat = (m_lat & ~ack) | rise;
            total = m_cnt + $countones(rise);
            m_cnt = (total > 255) ? 255 : total;
            m_s2  = m_s1;
            m_s1  = sensor_raw;
        end
    endtask

    function automatic int exp_id(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clean", sensor_clean, m_clean);
        chk("latched", event_latched, m_lat);
        chk("valid", event_valid, |m_lat);
        chk("id", event_id, exp_id(m_lat));
        chk("count", event_count, m_cnt);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; sensor_raw = 8'hFF; ack = '0;
        // reset with all lines high
        steps(2);
        chk("rst_clean", sensor_clean, 0);
        chk("rst_count", event_count, 0);
        rst = 1'b0;
        steps(5);
        chk("t1_e5_clean", sensor_clean, 8'h00);
        step();
        chk("t1_e6_clean", sensor_clean, 8'hFF);
        chk("t1_lat", event_latched, 8'hFF);
        chk("t1_id", event_id, 0);
        chk("t1_cnt", event_count, 8);
        sensor_raw = 8'h00; steps(7);
        ack = 8'hFF; step(); ack = '0;
        chk("t1_ackall", event_latched, 8'h00);
        // single rise on bit 0 then ack
        sensor_raw = 8'h01; steps(5);
        chk("t2_e5_clean", sensor_clean, 8'h00);
        step();
        chk("t2_e6_clean", sensor_clean, 8'h01);
        chk("t2_lat", event_latched, 8'h01);
        chk("t2_valid", event_valid, 1);
        chk("t2_cnt", event_count, 9);
        ack = 8'h01; step(); ack = '0;
        chk("t2_ack_lat", event_latched, 8'h00);
        chk("t2_ack_valid", event_valid, 0);
        // short glitch on bit 2
        sensor_raw = 8'h05; steps(3);
        sensor_raw = 8'h01; steps(8);
        chk("t3_clean", sensor_clean, 8'h01);
        chk("t3_lat", event_latched, 8'h00);
        chk("t3_cnt", event_count, 9);
        // two rises together
        sensor_raw = 8'h07; steps(6);
        chk("t4_lat", event_latched, 8'h06);
        chk("t4_id", event_id, 1);
        chk("t4_cnt", event_count, 11);
        ack = 8'h02; step(); ack = '0;
        chk("t4_ack_lat", event_latched, 8'h04);
        chk("t4_ack_id", event_id, 2);
        // ack and rise collide on bit 3
        sensor_raw = 8'h0F; steps(6);
        chk("t5_lat", event_latched, 8'h0C);
        sensor_raw = 8'h07; steps(7);
        sensor_raw = 8'h0F; steps(5);
        ack = 8'h08; step(); ack = '0;
        chk("t5_setwins", event_latched, 8'h0C);
        chk("t5_cnt", event_count, 13);
        // reset mid-debounce on bit 5
        sensor_raw = 8'h2F; steps(4);
        rst = 1'b1; step(); rst = 1'b0;
        steps(5);
        chk("t5_rst_e5", sensor_clean, 8'h00);
        step();
        chk("t5_rst_e6", sensor_clean, 8'h2F);
        chk("t5_rst_cnt", event_count, 5);
        // ena low freezes debounce
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sensor_raw = 8'($urandom);
            step();
        end
        chk("t6_frz_clean", sensor_clean, 8'h2F);
        chk("t6_frz_cnt", event_count, 5);
        ena = 1'b1; sensor_raw = 8'h2F; steps(8);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) sensor_raw[b] = ~sensor_raw[b];
            ena = ($urandom_range(0, 9) != 0);
            ack = 8'($urandom & $urandom);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; ena = 1'b1; ack = '0;
        // saturation
        for (int k = 0; k < 40; k++) begin
            sensor_raw = 8'hFF; steps(7);
            sensor_raw = 8'h00; steps(7);
        end
        chk("t6_sat", event_count, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            sensor_raw = 8'hFF; steps(7);
            sensor_raw = 8'h00; steps(7);
        end
        chk("t6_sat_hold", event_count, 8'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
